// File: rtl/amm_perf_meter.sv
`timescale 1ns/1ps
// amm_perf_meter
// Passive Avalon-MM performance monitor. Snoops the tester master's command
// and response signals without driving the bus. Up to MAX_OUTSTANDING
// pipelined read bursts are tracked in an in-order FIFO of
// {issue timestamp, remaining beats}. Per-burst latency (issue to last beat)
// feeds min/max/sum statistics. Read requests/words, read/write busy ticks
// and written units (bytes or beats, see ADDR_TYPE) are also counted.
//
// Build option: define AMM_PERF_SATURATE_EN to make every CNT_W counter
// (including sum_delay_o) saturate at all-ones instead of wrapping.
//
// Ports:
//   clk_i, rst_i (async, active-low)  clock / reset
//   reset_module_i                    synchronous statistics clear (tracker kept)
//   read_i, write_i, waitrequest_i,
//   readdatavalid_i, burstcount_i,
//   byteenable_i                      snooped Avalon-MM signals
//   read_request_amount_o             completed read bursts
//   read_word_count_o                 readdatavalid beats
//   min_delay_o / max_delay_o         burst latency extremes
//   sum_delay_o                       sum of burst latencies
//   read_ticks_o                      cycles with a tracked read in flight
//   write_ticks_o                     cycles with write_i high
//   write_unit_count_o                written bytes (BYTE) or beats (WORD)
//   outstanding_o                     tracker occupancy
//   overflow_o / unexpected_o         sticky error flags
module amm_perf_meter #(
    parameter int AMM_DATA_W      = 128,
    parameter int AMM_BURST_W     = 11,
    parameter     ADDR_TYPE       = "BYTE",
    parameter int MAX_OUTSTANDING = 4,
    parameter int DELAY_W         = 16,
    parameter int CNT_W           = 32,
    localparam int BYTE_PER_WORD  = AMM_DATA_W / 8,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     reset_module_i,
    input  logic                     read_i,
    input  logic                     write_i,
    input  logic                     waitrequest_i,
    input  logic                     readdatavalid_i,
    input  logic [AMM_BURST_W-1:0]   burstcount_i,
    input  logic [BYTE_PER_WORD-1:0] byteenable_i,
    output logic [CNT_W-1:0]         read_request_amount_o,
    output logic [CNT_W-1:0]         read_word_count_o,
    output logic [DELAY_W-1:0]       min_delay_o,
    output logic [DELAY_W-1:0]       max_delay_o,
    output logic [CNT_W-1:0]         sum_delay_o,
    output logic [CNT_W-1:0]         read_ticks_o,
    output logic [CNT_W-1:0]         write_ticks_o,
    output logic [CNT_W-1:0]         write_unit_count_o,
    output logic [OUT_W-1:0]         outstanding_o,
    output logic                     overflow_o,
    output logic                     unexpected_o
);

    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int PEND_W = $clog2(BYTE_PER_WORD) + 1;
    localparam bit WORD_MODE = (ADDR_TYPE == "WORD");
    localparam logic [31:0] LAT_MAX = 32'((64'd1 << DELAY_W) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
`ifdef AMM_PERF_SATURATE_EN
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
`else
        return a + b;
`endif
    endfunction

    logic [31:0]            ts;
    logic [31:0]            ts_mem  [MAX_OUTSTANDING];
    logic [AMM_BURST_W-1:0] rem_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [OUT_W-1:0]       occ;

    logic                   rd_acc, wr_acc, full, empty, push, pop, beat_hit;
    logic [AMM_BURST_W-1:0] head_rem, burst_len;
    logic [31:0]            lat_raw;
    logic [DELAY_W-1:0]     lat_clamped, lat_q;
    logic                   lat_vld;
    logic [PEND_W-1:0]      wu_next, wu_q;
    logic                   wu_vld;

    assign rd_acc    = read_i && !waitrequest_i;
    assign wr_acc    = write_i && !waitrequest_i;
    assign full      = (occ == OUT_W'(MAX_OUTSTANDING));
    assign empty     = (occ == '0);
    assign push      = rd_acc && !full;
    assign beat_hit  = readdatavalid_i && !empty;
    assign head_rem  = rem_mem[rd_ptr];
    assign pop       = beat_hit && (head_rem == AMM_BURST_W'(1));
    assign burst_len = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;

    // Modulo-2^32 difference, so a timestamp wrap between issue and
    // completion still yields the true latency.
    assign lat_raw     = ts - ts_mem[rd_ptr];
    assign lat_clamped = (lat_raw > LAT_MAX) ? '1 : lat_raw[DELAY_W-1:0];

    always_comb begin
        wu_next = '0;
        if (WORD_MODE) begin
            wu_next = PEND_W'(1);
        end else begin
            for (int i = 0; i < BYTE_PER_WORD; i++) begin
                wu_next = wu_next + PEND_W'(byteenable_i[i]);
            end
        end
    end

    // Push and in-place decrement never hit the same slot: a push into a
    // non-empty FIFO writes a slot other than the head, and a beat cannot
    // decrement anything while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ts_mem[wr_ptr]  <= ts;
            rem_mem[wr_ptr] <= burst_len;
        end
        if (beat_hit && !pop) begin
            rem_mem[rd_ptr] <= head_rem - AMM_BURST_W'(1);
        end
    end

    // Tracker and timestamp survive reset_module_i; only rst_i clears them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ts      <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            lat_q   <= '0;
            lat_vld <= 1'b0;
            wu_q    <= '0;
            wu_vld  <= 1'b0;
        end else begin
            ts      <= ts + 32'd1;
            lat_vld <= pop;
            lat_q   <= lat_clamped;
            wu_vld  <= wr_acc;
            wu_q    <= wu_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      occ <= occ + OUT_W'(1);
            else if (pop && !push) occ <= occ - OUT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            read_request_amount_o <= '0;
            read_word_count_o     <= '0;
            min_delay_o           <= '1;
            max_delay_o           <= '0;
            sum_delay_o           <= '0;
            read_ticks_o          <= '0;
            write_ticks_o         <= '0;
            write_unit_count_o    <= '0;
            overflow_o            <= 1'b0;
            unexpected_o          <= 1'b0;
        end else if (reset_module_i) begin
            read_request_amount_o <= '0;
            read_word_count_o     <= '0;
            min_delay_o           <= '1;
            max_delay_o           <= '0;
            sum_delay_o           <= '0;
            read_ticks_o          <= '0;
            write_ticks_o         <= '0;
            write_unit_count_o    <= '0;
            overflow_o            <= 1'b0;
            unexpected_o          <= 1'b0;
        end else begin
            if (lat_vld) begin
                read_request_amount_o <= cnt_add(read_request_amount_o, CNT_ONE);
                sum_delay_o           <= cnt_add(sum_delay_o, CNT_W'(lat_q));
                if (lat_q < min_delay_o) min_delay_o <= lat_q;
                if (lat_q > max_delay_o) max_delay_o <= lat_q;
            end
            if (readdatavalid_i) read_word_count_o <= cnt_add(read_word_count_o, CNT_ONE);
            if (!empty)          read_ticks_o      <= cnt_add(read_ticks_o, CNT_ONE);
            if (write_i)         write_ticks_o     <= cnt_add(write_ticks_o, CNT_ONE);
            if (wu_vld)          write_unit_count_o <= cnt_add(write_unit_count_o, CNT_W'(wu_q));
            if (rd_acc && full)          overflow_o   <= 1'b1;
            if (readdatavalid_i && empty) unexpected_o <= 1'b1;
        end
    end

    assign outstanding_o = occ;

endmodule

// File: tb/tb_amm_perf_meter.sv
`timescale 1ns/1ps
module tb_amm_perf_meter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rm = 1'b0, rd = 1'b0, wr = 1'b0, wt = 1'b0, dv = 1'b0;
    logic [10:0] bc = '0;
    logic [15:0] be = '0;

    logic [31:0] o_req, o_words, o_sum, o_rt, o_wt, o_wu;
    logic [15:0] o_min, o_max;
    logic [2:0]  o_out;
    logic        o_ovf, o_unx;

    int checks = 0;
    int failures = 0;
    bit check_en = 0;

    always #5 clk = ~clk;

    amm_perf_meter dut (
        .clk_i(clk), .rst_i(rst_n), .reset_module_i(rm),
        .read_i(rd), .write_i(wr), .waitrequest_i(wt),
        .readdatavalid_i(dv), .burstcount_i(bc), .byteenable_i(be),
        .read_request_amount_o(o_req), .read_word_count_o(o_words),
        .min_delay_o(o_min), .max_delay_o(o_max), .sum_delay_o(o_sum),
        .read_ticks_o(o_rt), .write_ticks_o(o_wt), .write_unit_count_o(o_wu),
        .outstanding_o(o_out), .overflow_o(o_ovf), .unexpected_o(o_unx)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int unsigned t; int unsigned rem; } rd_t;
    rd_t q[$];
    int unsigned now = 0;
    int unsigned m_req, m_words, m_min, m_max, m_sum, m_rt, m_wt, m_wu;
    bit m_ovf, m_unx;
    bit pl_v, pw_v;
    int unsigned pl, pw;

    function automatic void clear_stats();
        m_req = 0; m_words = 0; m_min = 16'hFFFF; m_max = 0; m_sum = 0;
        m_rt = 0; m_wt = 0; m_wu = 0; m_ovf = 0; m_unx = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            clear_stats();
            pl_v = 0; pw_v = 0; pl = 0; pw = 0;
        end else begin
            automatic bit was_full = (q.size() == MAXO);
            automatic bit busy = (q.size() != 0);
            automatic bit nl_v = 0, nw_v = 0;
            automatic int unsigned nl = 0, nw = 0;
            if (dv) begin
                m_words++;
                if (q.size() == 0) m_unx = 1;
                else begin
                    q[0].rem--;
                    if (q[0].rem == 0) begin
                        nl = now - q[0].t;
                        if (nl > 65535) nl = 65535;
                        nl_v = 1;
                        void'(q.pop_front());
                    end
                end
            end
            if (rd && !wt) begin
                if (was_full) m_ovf = 1;
                else q.push_back('{t: now, rem: (bc == 0) ? 1 : int'(bc)});
            end
            if (wr && !wt) begin nw = $countones(be); nw_v = 1; end
            if (pl_v) begin
                m_req++; m_sum += pl;
                if (pl < m_min) m_min = pl;
                if (pl > m_max) m_max = pl;
            end
            if (pw_v) m_wu += pw;
            if (busy) m_rt++;
            if (wr) m_wt++;
            if (rm) clear_stats();
            pl_v = nl_v; pl = nl; pw_v = nw_v; pw = nw;
            now++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && check_en) begin
            chk("req", o_req, m_req);
            chk("words", o_words, m_words);
            chk("min", o_min, m_min);
            chk("max", o_max, m_max);
            chk("sum", o_sum, m_sum);
            chk("read_ticks", o_rt, m_rt);
            chk("write_ticks", o_wt, m_wt);
            chk("write_units", o_wu, m_wu);
            chk("outstanding", o_out, q.size());
            chk("overflow", o_ovf, m_ovf);
            chk("unexpected", o_unx, m_unx);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        rd = 0; wr = 0; wt = 0; dv = 0; bc = '0; be = '0; rm = 0;
        repeat (n) step();
    endtask

    task automatic stat_clear();
        idle(0);
        rm = 1; step(); rm = 0; step();
        chk("clr_req", o_req, 0);
        chk("clr_min", o_min, 16'hFFFF);
        chk("clr_flags", {o_ovf, o_unx}, 0);
    endtask

    initial begin
        idle(2);
        rst_n = 1;
        #1;
        chk("rst_req", o_req, 0);
        chk("rst_min", o_min, 16'hFFFF);
        chk("rst_max", o_max, 0);
        chk("rst_out", o_out, 0);
        check_en = 1;
        step();

        // single read, latency 5
        rd = 1; bc = 1; step();
        rd = 0; bc = 0; repeat (4) step();
        dv = 1; step();
        idle(2);
        chk("s1_req", o_req, 1);
        chk("s1_words", o_words, 1);
        chk("s1_min", o_min, 5);
        chk("s1_max", o_max, 5);
        chk("s1_sum", o_sum, 5);
        stat_clear();

        // four pipelined bursts of 4, latencies 10/13/16/20
        for (int k = 0; k < 25; k++) begin
            rd = (k < 4); bc = 4;
            dv = ((k >= 7 && k <= 21) || k == 23);
            step();
            if (k == 3) chk("s2_peak", o_out, 4);
        end
        idle(2);
        chk("s2_req", o_req, 4);
        chk("s2_words", o_words, 16);
        chk("s2_min", o_min, 10);
        chk("s2_max", o_max, 20);
        chk("s2_sum", o_sum, 59);
        chk("s2_ovf", o_ovf, 0);
        stat_clear();

        // fifth read while full
        for (int k = 0; k < 12; k++) begin
            rd = (k < 5); bc = 1;
            dv = (k >= 6 && k <= 9);
            step();
        end
        idle(2);
        chk("s3_ovf", o_ovf, 1);
        chk("s3_req", o_req, 4);
        chk("s3_out", o_out, 0);
        idle(3);
        chk("s3_ovf_sticky", o_ovf, 1);
        stat_clear();

        // beat with empty tracker
        dv = 1; step();
        idle(1);
        chk("s4_unx", o_unx, 1);
        chk("s4_words", o_words, 1);
        chk("s4_req", o_req, 0);
        stat_clear();

        // BYTE mode writes with one stall
        wr = 1; be = 16'hFFFF; step();
        be = 16'h00FF; wt = 1; step();
        wt = 0; step();
        be = 16'h0001; step();
        idle(2);
        chk("s5_units", o_wu, 25);
        chk("s5_ticks", o_wt, 4);
        stat_clear();

        // reset_module_i mid-burst: burst still measured (latency 6)
        rd = 1; bc = 3; step();
        idle(2);
        dv = 1; step();
        rm = 1; step();
        rm = 0; dv = 0; step();
        dv = 1; step();
        idle(2);
        chk("s6a_req", o_req, 1);
        chk("s6a_words", o_words, 1);
        chk("s6a_min", o_min, 6);
        chk("s6a_max", o_max, 6);
        chk("s6a_sum", o_sum, 6);
        stat_clear();

        // rst_i mid-burst
        rd = 1; bc = 3; step();
        idle(2);
        dv = 1; step();
        dv = 0;
        rst_n = 0;
        #1;
        chk("s6b_out", o_out, 0);
        chk("s6b_words", o_words, 0);
        chk("s6b_min", o_min, 16'hFFFF);
        chk("s6b_rt", o_rt, 0);
        step();
        rst_n = 1;
        step();
        dv = 1; step(); step();
        idle(2);
        chk("s6b_unx", o_unx, 1);
        chk("s6b_words2", o_words, 2);
        chk("s6b_req", o_req, 0);
        chk("s6b_out2", o_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
